// File: rtl/present_core.sv
// Iterative PRESENT-80/128 encryption engine with on-the-fly key schedule.
// ROUNDS_PER_CYCLE round stages are chained combinationally per clock.
module present_core #(
    parameter int KEY_WIDTH        = 80,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                 Clk_ik,
    input  logic                 Reset_ir,
    input  logic                 Start_i,
    input  logic [63:0]          Data_ib,
    input  logic [KEY_WIDTH-1:0] Key_ib,
    output logic                 Ready_o,
    output logic                 Valid_o,
    output logic [63:0]          Data_ob
);

    generate
        if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : gBadKeyWidth
            $error("present_core: KEY_WIDTH must be 80 or 128");
        end
        if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 31) begin : gBadRounds
            $error("present_core: ROUNDS_PER_CYCLE must be in 1..31");
        end
    endgenerate

    // Round-counter injection point differs between the two key schedules
    localparam int CNT_LSB = (KEY_WIDTH == 128) ? 62 : 15;

    typedef enum logic {
        IDLE,
        RUN
    } fsmStateT;

    fsmStateT             fsmState;
    fsmStateT             fsmNext;
    logic [63:0]          blockReg;
    logic [KEY_WIDTH-1:0] keyReg;
    logic [4:0]           roundCnt;
    logic [63:0]          blockNext;
    logic [KEY_WIDTH-1:0] keyNext;
    logic                 lastCycle;

    function automatic logic [3:0] sBoxNibble(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;
            4'h1: return 4'h5;
            4'h2: return 4'h6;
            4'h3: return 4'hB;
            4'h4: return 4'h9;
            4'h5: return 4'h0;
            4'h6: return 4'hA;
            4'h7: return 4'hD;
            4'h8: return 4'h3;
            4'h9: return 4'hE;
            4'hA: return 4'hF;
            4'hB: return 4'h8;
            4'hC: return 4'h4;
            4'hD: return 4'h7;
            4'hE: return 4'h1;
            4'hF: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sBoxLayer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sBoxNibble(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] pLayer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            for (int b = 0; b < 4; b++) begin
                y[16*b + j] = x[4*j + b];
            end
        end
        return y;
    endfunction

    // Key register update following round number 'round'
    function automatic logic [KEY_WIDTH-1:0] keyUpdate(input logic [KEY_WIDTH-1:0] k,
                                                       input logic [4:0]           round);
        logic [KEY_WIDTH-1:0] r;
        r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
        r[KEY_WIDTH-1 -: 4] = sBoxNibble(r[KEY_WIDTH-1 -: 4]);
        if (KEY_WIDTH == 128) begin
            r[KEY_WIDTH-5 -: 4] = sBoxNibble(r[KEY_WIDTH-5 -: 4]);
        end
        r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ round;
        return r;
    endfunction

    // Unrolled round chain; stages past round 31 pass their inputs through
    always_comb begin
        logic [63:0]          s;
        logic [KEY_WIDTH-1:0] k;
        logic [5:0]           roundNum;
        s        = blockReg;
        k        = keyReg;
        roundNum = '0;
        for (int st = 0; st < ROUNDS_PER_CYCLE; st++) begin
            roundNum = {1'b0, roundCnt} + 6'(st);
            if (roundNum <= 6'd31) begin
                s = pLayer(sBoxLayer(s ^ k[KEY_WIDTH-1 -: 64]));
                k = keyUpdate(k, roundNum[4:0]);
            end
        end
        blockNext = s;
        keyNext   = k;
        lastCycle = ({1'b0, roundCnt} + 6'(ROUNDS_PER_CYCLE)) >= 6'd32;
    end

    always_ff @(posedge Clk_ik) begin
        if (Reset_ir) begin
            fsmState <= IDLE;
        end else begin
            fsmState <= fsmNext;
        end
    end

    always_comb begin
        fsmNext = fsmState;
        case (fsmState)
            IDLE:    if (Start_i) fsmNext = RUN;
            RUN:     if (lastCycle) fsmNext = IDLE;
            default: fsmNext = IDLE;
        endcase
    end

    always_comb begin
        Ready_o = (fsmState == IDLE);
    end

    always_ff @(posedge Clk_ik) begin
        if (Reset_ir) begin
            blockReg <= '0;
            keyReg   <= '0;
            roundCnt <= '0;
            Valid_o  <= 1'b0;
            Data_ob  <= '0;
        end else begin
            Valid_o <= 1'b0;
            case (fsmState)
                IDLE: begin
                    if (Start_i) begin
                        blockReg <= Data_ib;
                        keyReg   <= Key_ib;
                        roundCnt <= 5'd1;
                    end
                end
                RUN: begin
                    blockReg <= blockNext;
                    keyReg   <= keyNext;
                    if (lastCycle) begin
                        Data_ob <= blockNext ^ keyNext[KEY_WIDTH-1 -: 64];
                        Valid_o <= 1'b1;
                    end else begin
                        roundCnt <= roundCnt + 5'(ROUNDS_PER_CYCLE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_core.sv
// Directed bench for present_core: 80-bit cores at several unroll factors
// and 128-bit cores, all driven from shared stimulus.
module tb_present_core;

    localparam int NUM_CORES = 7;

    logic                          clk;
    logic                          reset;
    logic                          start;
    logic [63:0]                   dataIn;
    logic [79:0]                   key80;
    logic [127:0]                  key128;
    logic [NUM_CORES-1:0]          readyV;
    logic [NUM_CORES-1:0]          validV;
    logic [NUM_CORES-1:0][63:0]    dataV;

    int checkCount = 0;
    int errorCount = 0;

    // Cores 0..4: 80-bit with 1,2,4,7,31 rounds/cycle; cores 5,6: 128-bit with 1,3
    int rpcOfCore [NUM_CORES] = '{1, 2, 4, 7, 31, 1, 3};
    int latOfCore [NUM_CORES] = '{31, 16, 8, 5, 1, 31, 11};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : gCore80
            localparam int RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 7 : 31;
            present_core #(.KEY_WIDTH(80), .ROUNDS_PER_CYCLE(RPC)) dut (
                .Clk_ik   (clk),
                .Reset_ir (reset),
                .Start_i  (start),
                .Data_ib  (dataIn),
                .Key_ib   (key80),
                .Ready_o  (readyV[g]),
                .Valid_o  (validV[g]),
                .Data_ob  (dataV[g])
            );
        end
        for (g = 0; g < 2; g++) begin : gCore128
            localparam int RPC = (g == 0) ? 1 : 3;
            present_core #(.KEY_WIDTH(128), .ROUNDS_PER_CYCLE(RPC)) dut (
                .Clk_ik   (clk),
                .Reset_ir (reset),
                .Start_i  (start),
                .Data_ib  (dataIn),
                .Key_ib   (key128),
                .Ready_o  (readyV[5+g]),
                .Valid_o  (validV[5+g]),
                .Data_ob  (dataV[5+g])
            );
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one block for a single cycle; returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic [63:0] pt, input logic [79:0] k80, input logic [127:0] k128);
        @(negedge clk);
        dataIn = pt;
        key80  = k80;
        key128 = k128;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic runVector(input string name, input logic [63:0] pt, input logic [79:0] k80,
                             input logic [63:0] exp80, input bit chk128, input logic [63:0] exp128);
        int firstSeen [NUM_CORES];
        int pulses    [NUM_CORES];
        logic [63:0] got [NUM_CORES];
        int readyLow;
        logic readyAtDone;
        logic [63:0] expData;
        for (int i = 0; i < NUM_CORES; i++) begin
            firstSeen[i] = -1;
            pulses[i]    = 0;
            got[i]       = '0;
        end
        readyLow    = 0;
        readyAtDone = 1'b0;
        applyStimulus(pt, k80, 128'h0);
        checkOutput({name, " readyFall"}, 64'(readyV[0]), 64'h0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (validV[i]) begin
                    pulses[i]++;
                    if (firstSeen[i] < 0) begin
                        firstSeen[i] = n;
                        got[i]       = dataV[i];
                    end
                end
            end
            if (n <= 30 && !readyV[0]) readyLow++;
            if (n == 31) readyAtDone = readyV[0];
        end
        checkOutput({name, " readyLowCycles"}, 64'(readyLow), 64'd30);
        checkOutput({name, " readyAtDone"}, 64'(readyAtDone), 64'h1);
        checkOutput({name, " dataHold"}, dataV[0], exp80);
        for (int i = 0; i < NUM_CORES; i++) begin
            if (i < 5 || chk128) begin
                expData = (i < 5) ? exp80 : exp128;
                checkOutput($sformatf("%s core%0d rpc%0d data", name, i, rpcOfCore[i]), got[i], expData);
                checkOutput($sformatf("%s core%0d latency", name, i), 64'(firstSeen[i]), 64'(latOfCore[i]));
                checkOutput($sformatf("%s core%0d pulses", name, i), 64'(pulses[i]), 64'd1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulseCount;
        int lowCount;
        reset  = 1'b1;
        start  = 1'b0;
        dataIn = '0;
        key80  = '0;
        key128 = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NUM_CORES; i++) begin
            checkOutput($sformatf("reset core%0d ready", i), 64'(readyV[i]), 64'h1);
            checkOutput($sformatf("reset core%0d valid", i), 64'(validV[i]), 64'h0);
            checkOutput($sformatf("reset core%0d data", i), dataV[i], 64'h0);
        end
        reset = 1'b0;

        runVector("zeroZero", 64'h0, 80'h0, 64'h5579C1387B228445, 1'b1, 64'h96DB702A2E6900AF);
        runVector("zeroOnes", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, 64'h0);
        runVector("onesZero", {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, 64'h0);
        runVector("onesOnes", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, 64'h0);

        // Back-to-back: second start presented in the valid cycle of core 0
        applyStimulus(64'h0, 80'h0, 128'h0);
        repeat (31) @(negedge clk);
        checkOutput("b2b firstValid", 64'(validV[0]), 64'h1);
        checkOutput("b2b firstData", dataV[0], 64'h5579C1387B228445);
        checkOutput("b2b readyInValid", 64'(readyV[0]), 64'h1);
        dataIn = {64{1'b1}};
        key80  = 80'h0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b validDrop", 64'(validV[0]), 64'h0);
        checkOutput("b2b accepted", 64'(readyV[0]), 64'h0);
        repeat (15) @(negedge clk);
        checkOutput("b2b holdBetween", dataV[0], 64'h5579C1387B228445);
        repeat (15) @(negedge clk);
        checkOutput("b2b notEarly", 64'(validV[0]), 64'h0);
        @(negedge clk);
        checkOutput("b2b secondValid", 64'(validV[0]), 64'h1);
        checkOutput("b2b secondData", dataV[0], 64'hA112FFC72F68417B);

        // Start with different inputs in the middle of a run is ignored
        applyStimulus(64'h0, 80'h0, 128'h0);
        repeat (10) @(negedge clk);
        dataIn = {64{1'b1}};
        key80  = {80{1'b1}};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("midStart stillBusy", 64'(readyV[0]), 64'h0);
        repeat (20) @(negedge clk);
        checkOutput("midStart valid", 64'(validV[0]), 64'h1);
        checkOutput("midStart data", dataV[0], 64'h5579C1387B228445);

        // Reset around round 15 aborts the run
        applyStimulus(64'h0, {80{1'b1}}, 128'h0);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort ready", 64'(readyV[0]), 64'h1);
        checkOutput("abort valid", 64'(validV[0]), 64'h0);
        checkOutput("abort data", dataV[0], 64'h0);
        pulseCount = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (validV[0]) pulseCount++;
        end
        checkOutput("abort noPulse", 64'(pulseCount), 64'h0);
        runVector("afterAbort", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, 64'h0);

        // Start held together with reset must not launch anything
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        dataIn = 64'h0;
        key80  = 80'h0;
        repeat (5) @(negedge clk);
        checkOutput("resetStart ready", 64'(readyV[0]), 64'h1);
        checkOutput("resetStart valid", 64'(validV[4]), 64'h0);
        checkOutput("resetStart data", dataV[0], 64'h0);
        reset = 1'b0;
        start = 1'b0;
        pulseCount = 0;
        lowCount   = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (validV[4]) pulseCount++;
            if (!readyV[0]) lowCount++;
        end
        checkOutput("resetStart noPulse", 64'(pulseCount), 64'h0);
        checkOutput("resetStart stayIdle", 64'(lowCount), 64'h0);
        checkOutput("resetStart dataZero", dataV[4], 64'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
